// File: rtl/led_shift_rx.sv
// led_shift_rx: receiver for the serial LED shift interface.
// It synchronizes the four serial lines into the clk domain and assembles
// MSB-first frames. A frame of exactly WIDTH bits is presented on LED_q when
// LED_PEN rises. Any other length is rejected with a frame_err pulse.
module led_shift_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          RSTN,
    input  logic                          led_clk,
    input  logic                          led_sout,
    input  logic                          led_clrn,
    input  logic                          LED_PEN,
    output logic [WIDTH-1:0]              LED_q,
    output logic                          frame_valid,
    output logic                          frame_err,
    output logic [$clog2(WIDTH+2)-1:0]    bit_cnt,
    output logic                          busy
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_IDLE = '0;
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_OVER = CW'(WIDTH + 1);

    // Line positions inside the packed synchronizer vectors.
    localparam int L_CLK  = 0;
    localparam int L_SOUT = 1;
    localparam int L_CLRN = 2;
    localparam int L_PEN  = 3;
    localparam int NL     = 4;

    logic [NL-1:0]    pins;
    logic [NL-1:0]    line_s;        // synchronized lines
    logic [NL-1:0]    prev_reg;      // one cycle behind line_s, for edge detection
    logic             clk_rise_reg;  // registered led_clk rising edge
    logic             pen_rise_reg;  // registered LED_PEN rising edge
    logic [WIDTH-1:0] shreg_reg;

    assign pins = {LED_PEN, led_clrn, led_sout, led_clk};

    genvar gi;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;

            // Multi-flop synchronizer for one asynchronous line, cleared to 0 on reset.
            always_ff @(posedge clk or negedge RSTN) begin
                if (!RSTN) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins[gi]};
                end
            end

            assign line_s[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    // The edge-detect history and the registered rising-edge flags.
    // led_sout and led_clrn are consumed from prev_reg, so they arrive
    // together with the registered edges of led_clk and LED_PEN.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            prev_reg     <= '0;
            clk_rise_reg <= 1'b0;
            pen_rise_reg <= 1'b0;
        end else begin
            prev_reg     <= line_s;
            clk_rise_reg <= line_s[L_CLK] & ~prev_reg[L_CLK];
            pen_rise_reg <= line_s[L_PEN] & ~prev_reg[L_PEN];
        end
    end

    // Frame state machine. The counter value is the state: 0 means IDLE,
    // below WIDTH means SHIFT, WIDTH means FULL, WIDTH+1 means OVER.
    // Priority is clear, then simultaneous edges, then latch, then shift.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            shreg_reg   <= '0;
            bit_cnt     <= CNT_IDLE;
            LED_q       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (!prev_reg[L_CLRN]) begin
                shreg_reg <= '0;
                bit_cnt   <= CNT_IDLE;
            end else if (pen_rise_reg && clk_rise_reg) begin
                // Both edges in the same cycle: the bit cannot be placed, so drop the frame.
                frame_err <= 1'b1;
                shreg_reg <= '0;
                bit_cnt   <= CNT_IDLE;
            end else if (pen_rise_reg) begin
                if (bit_cnt == CNT_FULL) begin
                    LED_q       <= shreg_reg;
                    frame_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                    shreg_reg <= '0;
                end
                bit_cnt <= CNT_IDLE;
            end else if (clk_rise_reg) begin
                shreg_reg <= {shreg_reg[WIDTH-2:0], prev_reg[L_SOUT]};
                if (bit_cnt != CNT_OVER) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign busy = (bit_cnt != CNT_IDLE);

endmodule

// File: tb/tb_led_shift_rx.sv
// Directed testbench for led_shift_rx. Each check prints one line.
`timescale 1ns/1ps
module tb_led_shift_rx;

    logic        clk;
    logic        RSTN;
    logic        led_clk;
    logic        led_sout;
    logic        led_clrn;
    logic        LED_PEN;
    logic [15:0] LED_q;
    logic        frame_valid;
    logic        frame_err;
    logic [4:0]  bit_cnt;
    logic        busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    led_shift_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .RSTN        (RSTN),
        .led_clk     (led_clk),
        .led_sout    (led_sout),
        .led_clrn    (led_clrn),
        .LED_PEN     (LED_PEN),
        .LED_q       (LED_q),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .bit_cnt     (bit_cnt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("ok   %-18s got 0x%0h", tag, got);
        end else begin
            $display("FAIL %-18s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One serial bit: data set up one cycle early, clock high 4 and low 4 cycles.
    task automatic send_bit(input logic b);
        led_sout = b;
        tick(1);
        led_clk = 1'b1;
        tick(4);
        led_clk = 1'b0;
        tick(4);
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        logic [31:0] v;
        v = w;
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic clear_pulse();
        led_clrn = 1'b0;
        tick(4);
        led_clrn = 1'b1;
        tick(6);
    endtask

    // Pulse LED_PEN (optionally with led_clk rising together) and watch the result pulses.
    task automatic pulse_pen(input bit with_clk, output int nv, output int ne, output int first_v);
        nv = 0;
        ne = 0;
        first_v = -1;
        LED_PEN = 1'b1;
        if (with_clk) led_clk = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (frame_valid === 1'b1) begin
                nv++;
                if (first_v < 0) first_v = i;
            end
            if (frame_err === 1'b1) ne++;
            if (i == 4) begin
                LED_PEN = 1'b0;
                led_clk = 1'b0;
            end
        end
    endtask

    initial begin
        int nv, ne, fv;
        RSTN     = 1'b0;
        led_clk  = 1'b0;
        led_sout = 1'b0;
        led_clrn = 1'b1;
        LED_PEN  = 1'b0;
        tick(3);
        RSTN = 1'b1;
        tick(5);
        check("rst_q",     LED_q, 32'h0);
        check("rst_cnt",   bit_cnt, 32'd0);
        check("rst_busy",  busy, 32'd0);
        check("rst_valid", frame_valid, 32'd0);
        check("rst_err",   frame_err, 32'd0);

        // Valid frame.
        clear_pulse();
        send_word(32'hA5C3, 16);
        check("full_cnt",  bit_cnt, 32'd16);
        check("full_busy", busy, 32'd1);
        pulse_pen(1'b0, nv, ne, fv);
        check("v1_q",      LED_q, 32'hA5C3);
        check("v1_nvalid", nv, 32'd1);
        check("v1_lat",    fv, 32'd4);
        check("v1_nerr",   ne, 32'd0);
        check("v1_cnt",    bit_cnt, 32'd0);

        // Asynchronous reset mid-frame.
        send_word(32'h15, 5);
        check("mid_cnt",   bit_cnt, 32'd5);
        RSTN = 1'b0;
        #2;
        check("ar_q",      LED_q, 32'h0);
        check("ar_cnt",    bit_cnt, 32'd0);
        check("ar_busy",   busy, 32'd0);
        check("ar_valid",  frame_valid, 32'd0);
        check("ar_err",    frame_err, 32'd0);
        tick(2);
        RSTN = 1'b1;
        tick(5);
        check("rel_cnt",   bit_cnt, 32'd0);
        check("rel_busy",  busy, 32'd0);

        // Reload 0xA5C3.
        send_word(32'hA5C3, 16);
        pulse_pen(1'b0, nv, ne, fv);
        check("v2_q",      LED_q, 32'hA5C3);
        check("v2_nvalid", nv, 32'd1);

        // Short frame.
        send_word(32'h1234, 15);
        check("short_cnt", bit_cnt, 32'd15);
        pulse_pen(1'b0, nv, ne, fv);
        check("short_nerr", ne, 32'd1);
        check("short_nval", nv, 32'd0);
        check("short_q",   LED_q, 32'hA5C3);
        check("short_cnt0", bit_cnt, 32'd0);

        // Overflow.
        send_word(32'h3FFFF, 17);
        check("ovr17_cnt", bit_cnt, 32'd17);
        send_bit(1'b1);
        check("ovr18_cnt", bit_cnt, 32'd17);
        pulse_pen(1'b0, nv, ne, fv);
        check("ovr_nerr",  ne, 32'd1);
        check("ovr_nval",  nv, 32'd0);
        check("ovr_q",     LED_q, 32'hA5C3);

        // Latch from IDLE is an error.
        pulse_pen(1'b0, nv, ne, fv);
        check("idle_nerr", ne, 32'd1);
        check("idle_q",    LED_q, 32'hA5C3);

        // Clear mid-frame, then a full frame of 0x0001.
        send_word(32'hFF, 8);
        check("clr8_cnt",  bit_cnt, 32'd8);
        clear_pulse();
        check("clr_cnt",   bit_cnt, 32'd0);
        check("clr_busy",  busy, 32'd0);
        check("clr_q",     LED_q, 32'hA5C3);
        send_word(32'h0001, 16);
        pulse_pen(1'b0, nv, ne, fv);
        check("c_q",       LED_q, 32'h0001);
        check("c_nvalid",  nv, 32'd1);
        check("c_nerr",    ne, 32'd0);

        // Simultaneous led_clk and LED_PEN rise while FULL.
        send_word(32'h1234, 16);
        check("sim_full",  bit_cnt, 32'd16);
        pulse_pen(1'b1, nv, ne, fv);
        check("sim_nerr",  ne, 32'd1);
        check("sim_nval",  nv, 32'd0);
        check("sim_q",     LED_q, 32'h0001);
        check("sim_cnt",   bit_cnt, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/led_shift_rx.md
# led_shift_rx

Serial receiver for the LED shift interface that SPIO drives (`led_clk`, `led_sout`, `led_clrn`, `LED_PEN`). It oversamples the serial lines in the system clock domain, assembles frames MSB-first and checks frame length. On a valid `LED_PEN` strobe it presents the assembled word in parallel. It sits on the board side of the LED chain and is used as the in-fabric model and checker of the external shift-register LED driver.

## Interface
Parameters:
- `WIDTH`, default 16: bits per frame; also the width of `LED_q`.
- `SYNC_STAGES`, default 2: synchronizer flops per serial input (minimum 2).

Ports:
- `clk`: input, 1 bit. System clock (100 MHz domain); the only clock.
- `RSTN`: input, 1 bit. Asynchronous, active-low reset.
- `led_clk`: input, 1 bit. Serial shift clock from the transmitter; asynchronous to `clk`.
- `led_sout`: input, 1 bit. Serial data; valid on the `led_clk` rising edge.
- `led_clrn`: input, 1 bit. Active-low frame clear.
- `LED_PEN`: input, 1 bit. Parallel-enable strobe; its rising edge ends a frame.
- `LED_q`: output, `WIDTH` bits. Last accepted frame.
- `frame_valid`: output, 1 bit. One-cycle pulse when `LED_q` is updated.
- `frame_err`: output, 1 bit. One-cycle pulse when a frame is rejected.
- `bit_cnt`: output, `$clog2(WIDTH+2)` bits. Bits received in the current frame.
- `busy`: output, 1 bit. High while a frame is partially received (`bit_cnt` ≠ 0).

## Operation
- **Synchronization.** All four serial inputs pass through `SYNC_STAGES` flops, then one edge-detect register. The shift and the latch act only on the synchronized edges.
- **States.** The counter encodes the state:
  - IDLE: `bit_cnt` = 0.
  - SHIFT: 0 < `bit_cnt` < `WIDTH`.
  - FULL: `bit_cnt` = `WIDTH`.
  - OVER: `bit_cnt` = `WIDTH`+1. The counter saturates here.
- **Shift.** On a synchronized `led_clk` rising edge:
  - `shreg` ← {`shreg[WIDTH-2:0]`, `led_sout_s`}. The first bit received ends up in `LED_q[WIDTH-1]`.
  - `bit_cnt` increments, saturating at `WIDTH`+1.
  - `shreg` keeps shifting in OVER.
- **Clear.** While synchronized `led_clrn` is low:
  - `shreg` = 0 and `bit_cnt` = 0; the block goes to IDLE.
  - Shift and `LED_PEN` edges are ignored.
  - `LED_q` is unchanged.
- **Latch.** On a synchronized `LED_PEN` rising edge:
  - If in FULL: `LED_q` ← `shreg`, pulse `frame_valid`, `bit_cnt` → 0.
  - If in any other state (including IDLE): pulse `frame_err`, `LED_q` unchanged, `bit_cnt` → 0, `shreg` → 0.
- **Simultaneous edges.** A `LED_PEN` rise and a `led_clk` rise detected in the same `clk` cycle are a protocol violation. The shift is discarded, `frame_err` pulses, and `bit_cnt` and `shreg` go to 0.
- **Priority.** Clear, then the simultaneous-edge violation, then latch, then shift.
- **Reset.** `RSTN` low, asynchronously:
  - `LED_q` = 0, `shreg` = 0, `bit_cnt` = 0.
  - `frame_valid` = 0, `frame_err` = 0, `busy` = 0.
  - All synchronizer and edge flops = 0, so a line that is already high at release reads as a rising edge. For `led_clrn` this is harmless (high = not clearing).
  - A reset mid-frame discards the partial frame; `LED_q` still reads 0.
- **Output pulses.** `frame_valid` and `frame_err` are registered, mutually exclusive, and never high two cycles in a row for a single edge.

## Timing
- **Input latency.** Pin edge to internal action is `SYNC_STAGES`+1 `clk` cycles (3 by default).
  - A shift updates `bit_cnt` on the cycle after the edge is detected.
  - A latch updates `LED_q` and raises `frame_valid` together, `SYNC_STAGES`+2 cycles after the `LED_PEN` pin rise.
- **Sampling.** `led_sout` goes through the same synchronizer depth as `led_clk`. It must be stable from 1 `clk` before to `SYNC_STAGES`+1 `clk` after the `led_clk` rise.
- **Input pulse widths.**
  - `led_clk` high and low phases: at least `SYNC_STAGES`+2 `clk` cycles each.
  - `LED_PEN` high: at least `SYNC_STAGES`+1 cycles.
  - `led_clrn` low: at least `SYNC_STAGES`+1 cycles.
  - Narrower pulses may be missed; this is not checked.
- **Throughput.** One bit per `led_clk` period; a new frame may start on the cycle after a latch.

## Test plan
- **Reset.** Assert `RSTN`=0 mid-frame after 5 bits → all outputs 0 immediately, without waiting for a `clk` edge. Release → `bit_cnt`=0 and `busy`=0.
- **Valid frame.** Clear, shift 16 bits of 0xA5C3 MSB-first, then pulse `LED_PEN` → `LED_q`=0xA5C3 and `frame_valid` pulses once, 4 cycles after the `LED_PEN` pin rise; `bit_cnt` returns to 0.
- **Short frame.** Shift 15 bits, then pulse `LED_PEN` → `frame_err` pulses, `LED_q` keeps its previous value (0xA5C3), `bit_cnt`=0.
- **Overflow.** Shift 18 bits → `bit_cnt` saturates at 17. `LED_PEN` → `frame_err` pulses and `LED_q` is unchanged.
- **Clear mid-frame.** After 8 bits, hold `led_clrn` low for 4 cycles, then shift 16 bits of 0x0001 and pulse `LED_PEN` → `LED_q`=0x0001 and `frame_valid` pulses.
- **Simultaneous edges.** `led_clk` and `LED_PEN` rise in the same cycle while in FULL → `frame_err` pulses, `LED_q` unchanged, `bit_cnt`=0.
